regfile_dump_restore: RTL and testbench
=======================================

Name: regfile_dump_restore

Overview:
- Sequencer that sits on the register-file port set (read address/data, write address/data/enable) as the initiator instead of the CPU datapath.
- DUMP mode: reads all architectural registers in order and streams them out over a valid/ready interface.
- RESTORE mode: accepts a valid/ready stream and writes it back into the register file.
- Used for context save/restore and debug; the CPU is stalled while busy is high.

Parameters:
- NREGS, 32, number of registers walked; index range 0..NREGS-1.
- AW, 5, register address width; must satisfy 2^AW >= NREGS.
- DW, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_dump  in  1  request dump; sampled only in IDLE.
- start_restore  in  1  request restore; sampled only in IDLE.
- busy  out  1  high in DUMP, RESTORE and DONE; CPU stall.
- done  out  1  one-cycle pulse when a dump or restore completes.
- rf_raddr  out  AW  register-file read address (file reads combinationally).
- rf_rdata  in  DW  register-file read data for rf_raddr.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  DW  register-file write data.
- rf_wen  out  1  register-file write enable; file writes on the next rising clk.
- out_valid  out  1  dump word valid.
- out_ready  in  1  dump consumer ready.
- out_data  out  DW  dump word.
- out_idx  out  AW  register index of out_data.
- in_valid  in  1  restore word valid.
- in_ready  out  1  restore word accepted when high.
- in_data  in  DW  restore word; words arrive in index order 0..NREGS-1.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE and ptr to 0.
  - busy, done, out_valid, rf_wen, in_ready are 0.
  - out_data, out_idx, rf_raddr, rf_waddr, rf_wdata are 0.
  - Reset mid-operation aborts immediately. Register writes already committed are kept; a partially delivered dump is simply truncated.
- States: IDLE, DUMP, RESTORE, DONE.
- IDLE:
  - rf_raddr = 0.
  - start_dump goes to DUMP; start_restore goes to RESTORE.
  - If both are high, start_dump wins.
  - ptr is cleared on entry to either mode.
- DUMP:
  - rf_raddr = ptr, registered counter output.
  - Load condition: out_valid == 0, or out_valid && out_ready.
  - When ptr <= NREGS-1 and the load condition holds: out_data <= rf_rdata, out_idx <= ptr, out_valid <= 1, ptr <= ptr+1.
  - When ptr == NREGS and the final word is accepted: out_valid <= 0, go to DONE.
  - While out_valid && !out_ready, out_data and out_idx hold stable (no drop, no overwrite).
  - With out_ready held high, throughput is 1 word/cycle.
  - Latency: start_dump in cycle 0, DUMP in cycle 1, first out_valid (idx 0) in cycle 2, last word (idx NREGS-1) in cycle NREGS+1.
- RESTORE:
  - in_ready = 1, decoded from state; it is 0 in every other state.
  - On in_valid && in_ready: rf_waddr <= ptr, rf_wdata <= in_data, rf_wen <= (ptr != 0), ptr <= ptr+1.
  - Index 0 is consumed but never written (r0 stays 0).
  - rf_wen is a one-cycle pulse per accepted word; it is 0 in cycles with no handshake.
  - When ptr == NREGS-1 is accepted, go to DONE.
  - in_valid gaps stall the sequencer indefinitely with no timeout.
- DONE:
  - Lasts exactly 1 cycle with done = 1 and busy = 1, so the final rf_wen write commits while the CPU is still stalled.
  - Next state is IDLE.
  - start_* inputs seen during DONE are ignored.
- start_* inputs outside IDLE are ignored; they are not queued.
- Counter width: ptr is AW+1 bits so it can reach NREGS without wrap; rf_raddr and out_idx take the low AW bits.
- rf_wen is never asserted in IDLE, DUMP or DONE, except for the registered final write from RESTORE, which is visible in the DONE cycle.

Test Plan:
- Dump, ready always high: preload reg k = 0x100+k (r0 = 0), pulse start_dump → 32 consecutive out_valid beats from cycle 2, idx 0..31, data 0,0x101..0x11F. done pulses in cycle 34. busy returns low in cycle 35.
- Dump backpressure: out_ready toggles 1,0,0,1 repeating → every idx 0..31 appears exactly once, in order; out_data is stable across stalled cycles; no rf writes occur.
- Restore: pulse start_restore, stream in_data = 0xA000+k for k=0..31 with 2-cycle gaps → 31 rf_wen pulses to addrs 1..31 with matching data; r0 reads 0; done pulses 1 cycle after word 31.
- Simultaneous start_dump and start_restore in IDLE → DUMP entered; in_ready stays 0 throughout.
- Reset mid-restore after word 10 is accepted → all outputs 0 asynchronously. Regs 1..10 hold new values and regs 11..31 are unchanged. After reset, a fresh start_dump reports them that way.
- start_restore pulsed during DUMP and during DONE → ignored; dump completes normally; state returns to IDLE with no restore started.

Source files
------------

// File: rtl/regfile_dump_restore.sv
// Register-file dump/restore sequencer: takes over the register-file ports to
// stream every register out (DUMP) or write a stream back in (RESTORE).
module regfile_dump_restore #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_dump,
  input  logic          start_restore,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_wen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DUMP    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // ptr is one bit wider than an address so it can reach NREGS without wrapping
  localparam logic [AW:0] PTR_LAST = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          rf_wen_q, rf_wen_d;
  logic          load_ok;

  assign load_ok = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rf_wen_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_dump) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
        end else if (start_restore) begin
          state_d = ST_RESTORE;
          ptr_d   = '0;
        end
      end

      ST_DUMP: begin
        if (ptr_q <= PTR_LAST) begin
          if (load_ok) begin
            out_data_d  = rf_rdata;
            out_idx_d   = ptr_q[AW-1:0];
            out_valid_d = 1'b1;
            ptr_d       = ptr_q + PTR_ONE;
          end
        end else if (load_ok) begin
          // all words issued; leave once the last one has been taken
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
      end

      ST_RESTORE: begin
        if (in_valid) begin
          rf_waddr_d = ptr_q[AW-1:0];
          rf_wdata_d = in_data;
          rf_wen_d   = (ptr_q != '0);
          ptr_d      = ptr_q + PTR_ONE;
          if (ptr_q == PTR_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rf_wen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rf_wen_q    <= rf_wen_d;
    end
  end

  // DONE keeps busy high so the final restore write lands while the CPU is stalled
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign in_ready  = (state_q == ST_RESTORE);
  assign rf_raddr  = (state_q == ST_DUMP) ? ptr_q[AW-1:0] : '0;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_wen    = rf_wen_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_regfile_dump_restore.sv
// Self-checking bench for regfile_dump_restore: a behavioural register file plus
// a reference array of expected register contents, with randomized handshakes.
module tb_regfile_dump_restore;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_dump, start_restore;
  logic          busy, done;
  logic [AW-1:0] rf_raddr, rf_waddr, out_idx;
  logic [DW-1:0] rf_rdata, rf_wdata, out_data, in_data;
  logic          rf_wen, out_valid, out_ready, in_valid, in_ready;

  always #5 clk = ~clk;

  regfile_dump_restore #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_dump(start_dump), .start_restore(start_restore),
    .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  // Environment register file (never reset) and the expected contents
  logic [DW-1:0] rf [NREGS];
  logic [DW-1:0] model_rf [NREGS];

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (rf_wen) rf[rf_waddr] <= rf_wdata;
  end

  // Log of every write pulse the DUT issues
  int            wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            wen_when_idle = 0;

  always @(negedge clk) begin
    if (rst_n && rf_wen) begin
      wr_addr.push_back(int'(rf_waddr));
      wr_data.push_back(rf_wdata);
      if (!busy) wen_when_idle++;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sd, input logic sr, input logic ordy,
                               input logic ivld, input logic [DW-1:0] idata);
    start_dump    = sd;
    start_restore = sr;
    out_ready     = ordy;
    in_valid      = ivld;
    in_data       = idata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    checkOutput({pfx, "_busy"},      busy,      0);
    checkOutput({pfx, "_done"},      done,      0);
    checkOutput({pfx, "_out_valid"}, out_valid, 0);
    checkOutput({pfx, "_rf_wen"},    rf_wen,    0);
    checkOutput({pfx, "_in_ready"},  in_ready,  0);
    checkOutput({pfx, "_out_data"},  out_data,  0);
    checkOutput({pfx, "_out_idx"},   out_idx,   0);
    checkOutput({pfx, "_rf_raddr"},  rf_raddr,  0);
    checkOutput({pfx, "_rf_waddr"},  rf_waddr,  0);
    checkOutput({pfx, "_rf_wdata"},  rf_wdata,  0);
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_dump(input int ready_mode, input bit timed, input bit poke, input bit both);
    int            exp_idx [$];
    logic [DW-1:0] exp_data [$];
    int            beats = 0, cyc, bad_busy = 0, bad_inready = 0, wr_before;
    bit            stalled = 0, finished = 0;
    logic          rdy;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;

    for (int k = 0; k < NREGS; k++) begin
      exp_idx.push_back(k);
      exp_data.push_back(model_rf[k]);
    end
    wr_before = wr_addr.size();
    checkOutput("dump_idle_busy", busy, 0);
    applyStimulus(1, both, 1, 0, '0);

    for (cyc = 1; cyc <= 2000 && !finished; cyc++) begin
      next_cycle();
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(0, poke ? (done ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0, rdy, 0, '0);
      if (in_ready) bad_inready++;

      if (done) begin
        finished = 1;
        checkOutput("dump_beats", beats, NREGS);
        checkOutput("dump_valid_in_done", out_valid, 0);
        if (timed) checkOutput("dump_done_cycle", cyc, NREGS + 2);
        next_cycle();
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("dump_busy_after", busy, 0);
        if (poke) begin
          next_cycle();
          checkOutput("dump_no_restore", busy, 0);
        end
      end else begin
        if (!busy) bad_busy++;
        if (stalled) begin
          checkOutput("dump_stall_data", out_data, held_data);
          checkOutput("dump_stall_idx", out_idx, held_idx);
        end
        stalled = 0;
        if (out_valid) begin
          if (rdy) begin
            if (exp_idx.size() == 0) begin
              checkOutput("dump_extra_beat", 1, 0);
            end else begin
              checkOutput("dump_idx", out_idx, exp_idx.pop_front());
              checkOutput("dump_data", out_data, exp_data.pop_front());
              if (timed) checkOutput("dump_beat_cycle", cyc, 2 + beats);
            end
            beats++;
          end else begin
            stalled   = 1;
            held_data = out_data;
            held_idx  = out_idx;
          end
        end
      end
    end

    if (!finished) checkOutput("dump_timeout", 0, 1);
    checkOutput("dump_busy_low_midway", bad_busy, 0);
    checkOutput("dump_in_ready_seen", bad_inready, 0);
    checkOutput("dump_rf_writes", wr_addr.size() - wr_before, 0);
  endtask

  // abort_after >= 0 resets the DUT once that word index has been written
  task automatic run_restore(input bit rand_data, input bit rand_gaps, input int abort_after);
    logic [DW-1:0] words [NREGS];
    int            k = 0, gap = 0, cyc, last_acc = -10, base, nexp;
    int            bad_ready = 0, bad_busy = 0;
    bit            finished = 0, aborted = 0, vld;

    base = wr_addr.size();
    for (int j = 0; j < NREGS; j++) words[j] = rand_data ? DW'($urandom) : DW'(32'hA000 + j);
    checkOutput("restore_idle_in_ready", in_ready, 0);
    applyStimulus(0, 1, 0, 0, '0);

    for (cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      next_cycle();
      if (done) begin
        finished = 1;
        applyStimulus(0, 0, 0, 0, '0);
        checkOutput("restore_words", k, NREGS);
        checkOutput("restore_done_cycle", cyc, last_acc + 1);
        checkOutput("restore_done_busy", busy, 1);
        checkOutput("restore_final_wen", rf_wen, 1);
        checkOutput("restore_final_waddr", rf_waddr, NREGS - 1);
        checkOutput("restore_final_wdata", rf_wdata, words[NREGS-1]);
        next_cycle();
        checkOutput("restore_busy_after", busy, 0);
      end else begin
        if (!in_ready) bad_ready++;
        if (!busy) bad_busy++;
        vld = (k < NREGS) && (gap == 0);
        applyStimulus(0, 0, 0, vld, vld ? words[k] : DW'($urandom));
        if (vld) begin
          if (k != 0) model_rf[k] = words[k];
          last_acc = cyc;
          k++;
          gap = rand_gaps ? $urandom_range(0, 3) : 2;
          if (abort_after >= 0 && k == abort_after + 1) begin
            next_cycle();
            applyStimulus(0, 0, 0, 0, '0);
            checkOutput("abort_wen", rf_wen, 1);
            checkOutput("abort_waddr", rf_waddr, abort_after);
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1 check_reset_outputs("abort");
            @(negedge clk) rst_n = 1'b1;
            next_cycle();
            finished = 1;
            aborted  = 1;
          end
        end else if (gap > 0) begin
          gap--;
        end
      end
    end

    if (!finished) checkOutput("restore_timeout", 0, 1);
    checkOutput("restore_in_ready_low", bad_ready, 0);
    checkOutput("restore_busy_low", bad_busy, 0);
    nexp = aborted ? abort_after : NREGS - 1;
    checkOutput("restore_write_count", wr_addr.size() - base, nexp);
    for (int j = 0; j < nexp && (base + j) < wr_addr.size(); j++) begin
      checkOutput("restore_write_addr", wr_addr[base + j], j + 1);
      checkOutput("restore_write_data", wr_data[base + j], words[j + 1]);
    end
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) begin
      rf[k]       = (k == 0) ? '0 : DW'(32'h100 + k);
      model_rf[k] = rf[k];
    end
    applyStimulus(0, 0, 0, 0, '0);
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    next_cycle();

    run_dump(0, 1, 0, 0);
    run_dump(1, 0, 0, 0);
    run_restore(0, 0, -1);
    run_dump(2, 0, 0, 0);
    run_dump(2, 0, 0, 1);
    run_restore(1, 1, -1);
    run_dump(0, 1, 1, 0);
    run_restore(1, 0, 10);
    run_dump(2, 0, 0, 0);

    checkOutput("final_busy", busy, 0);
    checkOutput("final_r0", rf[0], 0);
    checkOutput("wen_outside_busy", wen_when_idle, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
